// File: rtl/base_gasket_fifo.sv
// base_gasket_fifo
//   Width-converting item FIFO. Up to ni items enter per beat and up to no
//   items leave per beat. An optional end-of-stream marker, with sideband
//   data, travels behind the items of the beat that carried it.
//   The data path is fully registered: pushed items appear one cycle later.
//
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   i_r        : input ready, a function of stored state only
//   i_v, i_nv  : input valid, item count on this beat (0..ni)
//   i_d        : input items, lane 0 (low bits) oldest
//   i_e, i_ed  : end marker after this beat's items, marker sideband
//   o_r        : output ready
//   o_nr       : items the consumer wants to take (1..no)
//   o_v, o_nv  : output valid, number of items presented on o_d
//   o_d        : oldest stored items, lane 0 oldest, unused lanes zero
//   o_e, o_ed  : end marker presented, its sideband
//   o_cnt      : current item occupancy
module base_gasket_fifo #(
  parameter int width     = 1,
  parameter int ewidth    = 1,
  parameter int ni        = 2,
  parameter int no        = 2,
  parameter int depth     = ni + no,
  parameter int ni_width  = $clog2(ni + 1),
  parameter int no_width  = $clog2(no + 1),
  parameter int cnt_width = $clog2(depth + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  i_r,
  input  logic                  i_v,
  input  logic [ni_width-1:0]   i_nv,
  input  logic [ni*width-1:0]   i_d,
  input  logic                  i_e,
  input  logic [ewidth-1:0]     i_ed,
  input  logic                  o_r,
  output logic                  o_v,
  output logic [no_width-1:0]   o_nv,
  output logic [no*width-1:0]   o_d,
  output logic                  o_e,
  output logic [ewidth-1:0]     o_ed,
  input  logic [no_width-1:0]   o_nr,
  output logic [cnt_width-1:0]  o_cnt
);

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // items[0] is always the oldest stored item
  logic [width-1:0]     items     [depth];
  logic [width-1:0]     items_nxt [depth];
  logic [cnt_width-1:0] cnt;
  logic                 e_pend;
  logic [ewidth-1:0]    e_data;

  logic push;
  logic pop;
  int   cnt_i;
  int   pop_n;
  int   push_n;
  int   keep_n;
  int   cnt_nxt;

  assign cnt_i = int'(cnt);

  // Ready only looks at registered state, so a full ni-lane beat always fits.
  assign i_r   = !e_pend && (cnt_i <= depth - ni);
  // The marker can only be presented once every item ahead of it fits on o_d.
  assign o_e   = e_pend && (cnt_i <= no);
  assign o_v   = (cnt_i >= int'(o_nr)) || o_e;
  assign o_nv  = no_width'(min_int(cnt_i, no));
  assign o_cnt = cnt;
  assign o_ed  = e_pend ? e_data : '0;

  always_comb begin
    o_d = '0;
    for (int k = 0; k < no; k++) begin
      if (k < cnt_i) o_d[k*width +: width] = items[k];
    end
  end

  assign push    = i_v && i_r;
  assign pop     = o_v && o_r;
  // A marker pop drains everything left, whatever o_nr asks for.
  assign pop_n   = !pop ? 0 : (o_e ? cnt_i : int'(o_nr));
  assign push_n  = push ? int'(i_nv) : 0;
  assign keep_n  = cnt_i - pop_n;
  assign cnt_nxt = keep_n + push_n;

  // Survivors shift down by pop_n; new lanes land right behind them.
  // Entries beyond the new occupancy are cleared.
  always_comb begin
    for (int j = 0; j < depth; j++) begin
      items_nxt[j] = '0;
      for (int p = 0; p <= no; p++) begin
        if ((p == pop_n) && (j + p < depth) && (j < keep_n)) items_nxt[j] = items[j+p];
      end
      for (int k = 0; k < ni; k++) begin
        if ((j == keep_n + k) && (k < push_n)) items_nxt[j] = i_d[k*width +: width];
      end
    end
  end

  // Storage stage: items, occupancy and the pending marker update together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      e_pend <= 1'b0;
      e_data <= '0;
      for (int j = 0; j < depth; j++) items[j] <= '0;
    end else begin
      cnt <= cnt_width'(cnt_nxt);
      for (int j = 0; j < depth; j++) items[j] <= items_nxt[j];
      // A push is refused while a marker is pending, so these never coincide.
      if (pop && o_e) begin
        e_pend <= 1'b0;
        e_data <= '0;
      end else if (push && i_e) begin
        e_pend <= 1'b1;
        e_data <= i_ed;
      end
    end
  end

endmodule
